enet_tx_narrow: RTL and testbench

ENET_TX_NARROW -- requirements
Module: enet_tx_narrow

---
 rtl/enet_tx_narrow.sv | 113 +++++++++++
 tb/tb_enet_tx_narrow.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/enet_tx_narrow.sv
// Narrow Ethernet transmit serializer: splits source bytes into GMII (8b),
// MII (4b) or RMII (2b) beats, LSB first, advancing only on tick.
module enet_tx_narrow (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic [1:0] mode,
    input  logic       byte_valid,
    input  logic [7:0] byte_data,
    input  logic       byte_er,
    output logic       byte_ready,
    output logic [7:0] txd,
    output logic       tx_en,
    output logic       tx_er
);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t     state, state_nxt;
    logic [1:0] cnt, cnt_nxt;
    logic [1:0] mode_q, mode_nxt;
    logic [7:0] sreg, sreg_nxt;
    logic [7:0] txd_nxt;
    logic       tx_en_nxt, tx_er_nxt;
    logic       at_last, accept;
    logic [1:0] acc_mode;

    function automatic logic [1:0] last_of(input logic [1:0] m);
        case (m)
            2'b01:   return 2'd1;
            2'b10:   return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

    function automatic logic [7:0] beat_of(input logic [1:0] m, input logic [7:0] d);
        case (m)
            2'b00:   return d;
            2'b01:   return {4'b0, d[3:0]};
            2'b10:   return {6'b0, d[1:0]};
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] rest_of(input logic [1:0] m, input logic [7:0] d);
        case (m)
            2'b01:   return {4'b0, d[7:4]};
            2'b10:   return {2'b0, d[7:2]};
            default: return 8'h00;
        endcase
    endfunction

    // cnt is the index of the beat currently on txd
    always_comb begin
        at_last    = (state == SHIFT) && (cnt == last_of(mode_q));
        byte_ready = !rst && tick && (((state == IDLE) && (mode != 2'b11)) || at_last);
        accept     = byte_valid && byte_ready;
        acc_mode   = (state == IDLE) ? mode : mode_q;

        state_nxt  = state;
        cnt_nxt    = cnt;
        mode_nxt   = mode_q;
        sreg_nxt   = sreg;
        txd_nxt    = txd;
        tx_en_nxt  = tx_en;
        tx_er_nxt  = tx_er;

        if (tick) begin
            if (accept) begin
                state_nxt = SHIFT;
                mode_nxt  = acc_mode;
                txd_nxt   = beat_of(acc_mode, byte_data);
                sreg_nxt  = rest_of(acc_mode, byte_data);
                cnt_nxt   = 2'd0;
                tx_en_nxt = 1'b1;
                tx_er_nxt = byte_er;
            end else if ((state == SHIFT) && !at_last) begin
                txd_nxt   = beat_of(mode_q, sreg);
                sreg_nxt  = rest_of(mode_q, sreg);
                cnt_nxt   = cnt + 2'd1;
            end else begin
                // end of frame, or idle with nothing accepted
                state_nxt = IDLE;
                cnt_nxt   = 2'd0;
                sreg_nxt  = 8'h00;
                txd_nxt   = 8'h00;
                tx_en_nxt = 1'b0;
                tx_er_nxt = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= 2'd0;
            mode_q <= 2'b00;
            sreg   <= 8'h00;
            txd    <= 8'h00;
            tx_en  <= 1'b0;
            tx_er  <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            mode_q <= mode_nxt;
            sreg   <= sreg_nxt;
            txd    <= txd_nxt;
            tx_en  <= tx_en_nxt;
            tx_er  <= tx_er_nxt;
        end
    end

endmodule

// File: tb/tb_enet_tx_narrow.sv
// Scoreboard bench for enet_tx_narrow: driver pushes expected beats on each
// accept, an independent monitor pops and compares on every tick edge.
module tb_enet_tx_narrow;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick;
    logic [1:0] mode;
    logic       byte_valid;
    logic [7:0] byte_data;
    logic       byte_er;
    logic       byte_ready;
    logic [7:0] txd;
    logic       tx_en;
    logic       tx_er;

    enet_tx_narrow dut (
        .clk(clk), .rst(rst), .tick(tick), .mode(mode),
        .byte_valid(byte_valid), .byte_data(byte_data), .byte_er(byte_er),
        .byte_ready(byte_ready), .txd(txd), .tx_en(tx_en), .tx_er(tx_er)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    logic [8:0] exp_q[$];   // {tx_er, txd}
    logic mon_en = 1'b0;

    // model: frame activity and beats still to come for the current byte
    logic       m_active = 1'b0;
    int         m_left   = 0;
    logic [1:0] m_mode   = 2'b00;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    function automatic int nbeats(input logic [1:0] m);
        return (m == 2'b00) ? 1 : (m == 2'b01) ? 2 : 4;
    endfunction

    task automatic step(input logic t, input logic v, input logic [7:0] d,
                        input logic e, input logic [1:0] m);
        logic exp_rdy;
        logic [1:0] fm;
        int n, w;
        @(negedge clk);
        tick = t; byte_valid = v; byte_data = d; byte_er = e; mode = m;
        #1;
        exp_rdy = t && (m_active ? (m_left == 0) : (m != 2'b11));
        chk("byte_ready", {7'b0, byte_ready}, {7'b0, exp_rdy});
        if (exp_rdy && v) begin
            fm = m_active ? m_mode : m;
            m_mode = fm;
            n = nbeats(fm);
            w = 8 / n;
            for (int k = 0; k < n; k++)
                exp_q.push_back({e, 8'((d >> (k * w)) & ((1 << w) - 1))});
            m_active = 1'b1;
            m_left   = n - 1;
        end else if (t && m_active) begin
            if (m_left > 0) m_left--;
            else m_active = 1'b0;
        end
    endtask

    task automatic slow_step(input logic v, input logic [7:0] d, input logic e, input logic [1:0] m);
        step(1'b1, v, d, e, m);
        for (int i = 0; i < 9; i++) step(1'b0, 1'b0, 8'h00, 1'b0, m);
    endtask

    // monitor
    initial begin
        logic t_s;
        logic [8:0] got, exp;
        logic [9:0] prev;
        prev = '0;
        forever begin
            @(posedge clk);
            t_s = tick;
            #1;
            if (mon_en && !rst) begin
                if (!t_s) begin
                    chk("hold_txd", txd, prev[7:0]);
                    chk("hold_en_er", {6'b0, tx_en, tx_er}, {6'b0, prev[9:8]});
                end else if (tx_en) begin
                    got = {tx_er, txd};
                    if (exp_q.size() == 0) chk("unexpected_beat", got[7:0], 8'hxx);
                    else begin
                        exp = exp_q.pop_front();
                        chk("beat_txd", got[7:0], exp[7:0]);
                        chk("beat_er", {7'b0, got[8]}, {7'b0, exp[8]});
                    end
                end else begin
                    chk("idle_out", {txd[6:0], tx_er}, 8'h00);
                    chk("idle_txd7", {7'b0, txd[7]}, 8'h00);
                    chk("frame_short", 8'(exp_q.size()), 8'h00);
                end
            end
            prev = {tx_en, tx_er, txd};
        end
    end

    initial begin
        int slow, cyc;
        logic [1:0] m;
        rst = 1'b1; tick = 1'b0; mode = 2'b00; byte_valid = 1'b0; byte_data = 8'h00; byte_er = 1'b0;
        #1;
        chk("rst_txd", txd, 8'h00);
        chk("rst_en_er_rdy", {5'b0, tx_en, tx_er, byte_ready}, 8'h00);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        mon_en = 1'b1;

        // GMII back-to-back pair
        step(1, 1, 8'h55, 0, 2'b00);
        step(1, 1, 8'hD5, 0, 2'b00);
        step(1, 0, 8'h00, 0, 2'b00);
        step(1, 0, 8'h00, 0, 2'b00);
        // MII single byte
        step(1, 1, 8'hA5, 0, 2'b01);
        step(1, 0, 8'h00, 0, 2'b01);
        step(1, 0, 8'h00, 0, 2'b01);
        step(1, 0, 8'h00, 0, 2'b01);
        // RMII at 1-in-10 with error flag
        slow_step(1, 8'hE4, 1, 2'b10);
        for (int i = 0; i < 4; i++) slow_step(0, 8'h00, 0, 2'b10);
        // RMII, mode switched to GMII mid-frame; next frame is GMII
        step(1, 1, 8'h9C, 0, 2'b10);
        step(1, 0, 8'h00, 0, 2'b10);
        step(1, 1, 8'h00, 0, 2'b00);
        step(1, 0, 8'h00, 0, 2'b00);
        step(1, 0, 8'h00, 0, 2'b00);
        step(1, 1, 8'h7E, 0, 2'b00);
        step(1, 0, 8'h00, 0, 2'b00);
        step(1, 0, 8'h00, 0, 2'b00);
        // reserved mode never accepts
        for (int i = 0; i < 20; i++) step(1, 1, 8'(i), 0, 2'b11);

        // MII reset during beat 1
        step(1, 1, 8'h3C, 0, 2'b01);
        step(1, 0, 8'h00, 0, 2'b01);
        @(negedge clk);
        mon_en = 1'b0;
        rst = 1'b1;
        #1;
        chk("async_rst_txd", txd, 8'h00);
        chk("async_rst_en_rdy", {6'b0, tx_en, byte_ready}, 8'h00);
        exp_q.delete();
        m_active = 1'b0; m_left = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        mon_en = 1'b1;
        step(1, 1, 8'h12, 0, 2'b01);
        step(1, 0, 8'h00, 0, 2'b01);
        step(1, 0, 8'h00, 0, 2'b01);
        step(1, 0, 8'h00, 0, 2'b01);

        // randomized traffic per mode and rate
        for (int r = 0; r < 6; r++) begin
            m = 2'(r % 3);
            slow = r / 3;
            cyc = 0;
            for (int i = 0; i < 300; i++) begin
                step(slow ? ((cyc % 10) == 0) : 1'b1,
                     $urandom_range(0, 3) != 0, 8'($urandom), 1'($urandom),
                     ($urandom_range(0, 15) == 0) ? 2'($urandom) : m);
                cyc++;
            end
            for (int i = 0; i < 12; i++) step(1, 0, 8'h00, 0, m);
        end

        step(1, 0, 8'h00, 0, 2'b00);
        chk("queue_drained", 8'(exp_q.size()), 8'h00);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
